// File: rtl/vga_index_fetcher.sv
// VGA raster generator and frame-buffer index fetcher with a 2-cycle aligned output pipeline.
// Optional 320x240 source with 2x2 pixel replication when VGA_PIXEL_DOUBLE_EN is defined.
module vga_index_fetcher #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19
) (
  input  logic              vgaClk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        color_index,
  output logic              videoOn,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Sync flags are carried active-high so a cleared pipeline reads as "not in sync".
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic fs;
  } flags_t;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last, frame_wrap;
  flags_t        st0;
  flags_t [2:1]  fl_pipe;

  assign h_last     = (h_cnt == H_LAST);
  assign v_last     = (v_cnt == V_LAST);
  assign frame_wrap = h_last && v_last;

  always_comb begin
    st0     = '0;
    st0.vis = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    st0.hs  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    st0.vs  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    st0.fs  = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge vgaClk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

`ifdef VGA_PIXEL_DOUBLE_EN
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE / 2);

  logic [ADDR_W-1:0] line_base, addr_live, addr_q;

  assign addr_live = line_base + ADDR_W'(h_cnt >> 1);
  assign mem_addr  = st0.vis ? addr_live : addr_q;

  // Each source line is shown twice, so the base moves on only after odd lines.
  always_ff @(posedge vgaClk or negedge rst) begin
    if (!rst) begin
      line_base <= '0;
      addr_q    <= '0;
    end else begin
      if (st0.vis) addr_q <= addr_live;
      if (frame_wrap)
        line_base <= '0;
      else if (h_last && (v_cnt < V_ACT_C) && v_cnt[0])
        line_base <= line_base + LINE_STEP;
    end
  end
`else
  logic [ADDR_W-1:0] ptr;

  assign mem_addr = ptr;

  // Raster-order pointer; only moves on visible pixels, so it holds through blanking.
  always_ff @(posedge vgaClk or negedge rst) begin
    if (!rst)
      ptr <= '0;
    else if (frame_wrap)
      ptr <= '0;
    else if (st0.vis)
      ptr <= ptr + 1'b1;
  end
`endif

  always_ff @(posedge vgaClk or negedge rst) begin
    if (!rst) begin
      fl_pipe     <= '0;
      color_index <= 8'h00;
    end else begin
      fl_pipe[1]  <= st0;
      fl_pipe[2]  <= fl_pipe[1];
      color_index <= fl_pipe[1].vis ? mem_rdata : 8'h00;
    end
  end

  assign videoOn     = fl_pipe[2].vis;
  assign hsync       = ~fl_pipe[2].hs;
  assign vsync       = ~fl_pipe[2].vs;
  assign frame_start = fl_pipe[2].fs;
endmodule

// File: doc/vga_index_fetcher.md
# vga_index_fetcher

Display front end that generates 640x480@60 VGA raster timing, walks the frame buffer in raster order, and presents an aligned `color_index`/`videoOn` pair to the palette stage. It is the producer side of the palette lookup interface: it sits between the frame-buffer RAM and the palette/RGB stage. Sync outputs go to the HDMI/VGA encoder alongside the palette stage's RGB.

## Interface
Parameters:
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync pulse width, in pixels.
- `H_BP`, default 48: horizontal back porch, in pixels.
- `V_ACTIVE`, default 480: visible lines per frame.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync pulse width, in lines.
- `V_BP`, default 33: vertical back porch, in lines.
- `ADDR_W`, default 19: frame-buffer address width (307200 < 2^19).

Ports (one clock; reset is asynchronous and active-low):
- `vgaClk` input, 1 bit: pixel clock (25.175 MHz nominal).
- `rst` input, 1 bit: asynchronous, active-low reset.
- `mem_addr` output, `ADDR_W` bits: frame-buffer read address.
- `mem_rdata` input, 8 bits: frame-buffer data. Synchronous RAM, 1-cycle read latency.
- `color_index` output, 8 bits: palette index for the current pixel.
- `videoOn` output, 1 bit: high while the current pixel is visible.
- `hsync` output, 1 bit: horizontal sync, active-low.
- `vsync` output, 1 bit: vertical sync, active-low.
- `frame_start` output, 1 bit: one-cycle pulse, aligned with the first visible pixel of each frame.

## Operation
- Counters:
  - `hCount` runs 0..H_TOTAL-1, where H_TOTAL = 800.
  - `vCount` runs 0..V_TOTAL-1, where V_TOTAL = 525. It advances when `hCount` wraps.
  - Both wrap to 0 together at (799, 524).
- Visible region: `hCount < H_ACTIVE` and `vCount < V_ACTIVE`.
- Sync regions:
  - hsync is asserted (low) for H_ACTIVE+H_FP ≤ `hCount` < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync is asserted (low) for lines 490..491.
- Address generation, full resolution (default):
  - A running pointer increments by 1 on every visible pixel.
  - It clears to 0 when (`hCount`, `vCount`) = (799, 524).
  - `mem_addr` equals the pointer during visible pixels and holds its value outside them.
  - The last address of a frame is 307199. No multiplier is used.
- Output pipeline, stage 0 (cycle n): counters; `mem_addr` is driven combinationally from the pointer.
- Output pipeline, stage 1 (cycle n+1): `mem_rdata` is valid. Stage-0 flags (visible, hsync, vsync, first-pixel) are delayed one register.
- Output pipeline, stage 2 (cycle n+2): registered outputs.
  - `color_index` = `mem_rdata` when the delayed visible flag is set, else 0x00.
  - `videoOn`, `hsync`, `vsync` and `frame_start` are the flags delayed twice.
- All five outputs share identical latency, so sync-to-pixel relationship is unchanged from the counter domain.
- Reset (`rst`=0, at any time, including mid-line or mid-frame):
  - `hCount`, `vCount`, pointer and all pipeline flags go to 0.
  - Output values under reset: `mem_addr`=0, `color_index`=0x00, `videoOn`=0, `hsync`=1, `vsync`=1, `frame_start`=0.
  - On release the raster restarts at (0,0).
  - No spurious `frame_start` pulse is generated until stage 2 of the first (0,0) pixel.

## Timing
- Latency from counter at (h,v) to outputs for that pixel: 2 `vgaClk` cycles.
- After reset release:
  - The first visible `color_index` (address 0 data) and `videoOn`=1 appear 2 cycles after the first active clock edge.
  - `frame_start`=1 is asserted in that same cycle.
- `videoOn` pattern: high for 640 consecutive cycles, then low for 160. Per frame: 480 such lines followed by 45 fully low lines.
- hsync low width: exactly 96 cycles per line.
- vsync low width: exactly 2×800 = 1600 cycles per frame.
- Frame period: 420000 cycles.
- `color_index` is 0x00 whenever `videoOn`=0, regardless of `mem_rdata`.

## Configuration
- Macro: `VGA_PIXEL_DOUBLE_EN`.
- Defined: the frame buffer is 320x240 and each source pixel is replicated 2x2.
  - `mem_addr` = lineBase + (`hCount` >> 1).
  - lineBase advances by 320 after each odd visible line and clears at frame wrap.
  - Last address of a frame is 76799.
  - Raster timing and output latency are unchanged.
- Undefined: 640x480 direct mapping as described in Operation.

## Test plan
- Reset: hold `rst`=0 for 5 cycles, driving `mem_rdata`=0xFF, then release. Required during reset: `hsync`=1, `vsync`=1, `videoOn`=0, `color_index`=0x00, `mem_addr`=0. After release: `videoOn`=1 and `frame_start`=1 on cycle 2.
- Latency: RAM model returns data = addr[7:0]. Required: on the first visible line, `color_index` sequence 0x00,0x01,0x02… starts 2 cycles after release; `videoOn` is high for exactly 640 cycles.
- Line timing: count cycles on line 0. Required: `hsync` is low for 96 cycles, starting 656 cycles after that line's first `videoOn`=1; the next `videoOn` rise comes 800 cycles after the first.
- Frame wrap: run 2 frames. Required:
  - `mem_addr` reaches 307199 at (639,479), then reads 0 at the next frame's (0,0).
  - `vsync` is low for 1600 cycles.
  - `frame_start` pulses exactly once per 420000 cycles.
- Mid-frame reset: assert `rst` at line 200, pixel 300. Required: outputs take reset values immediately (asynchronously); after release, the raster restarts with `mem_addr`=0.
- `VGA_PIXEL_DOUBLE_EN` defined: required `mem_addr` on line 0 is 0,0,1,1,…,319,319; line 1 repeats line 0; line 2 starts at 320; the last address is 76799.
